mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sits directly downstream of the 5-stage RV32I datapath.
- Merges the datapath's split instruction-fetch port and data-memory port into one shared memory/cache port.
- Arbitrates between the two sides, latches the winning request, and holds it stable on the shared port until the memory responds.
- Routes the read data and a single-cycle response back to the requesting side.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses. Byte-enable width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on the rising edge of clk).
- inst_read  in  1  fetch request; held high by the requester until inst_resp.
- inst_addr  in  ADDR_WIDTH  fetch address.
- inst_rdata  out  DATA_WIDTH  fetch data; valid when inst_resp=1.
- inst_resp  out  1  one-cycle fetch completion pulse.
- data_read  in  1  load request; held high until data_resp.
- data_write  in  1  store request; held high until data_resp.
- data_addr  in  ADDR_WIDTH  load/store address.
- data_wdata  in  DATA_WIDTH  store data.
- data_mbe  in  DATA_WIDTH/8  store byte enables.
- data_rdata  out  DATA_WIDTH  load data; valid when data_resp=1.
- data_resp  out  1  one-cycle load/store completion pulse.
- mem_read  out  1  shared-port read strobe; registered.
- mem_write  out  1  shared-port write strobe; registered.
- mem_addr  out  ADDR_WIDTH  shared-port address; registered.
- mem_wdata  out  DATA_WIDTH  shared-port write data; registered.
- mem_mbe  out  DATA_WIDTH/8  shared-port byte enables; registered.
- mem_rdata  in  DATA_WIDTH  shared-port read data.
- mem_resp  in  1  shared-port completion; a single cycle high.

Behaviour:

States and transitions:
- State machine states: IDLE, SERVE_I, SERVE_D.
- Reset (rst=0 at a clock edge), from any state including mid-transaction:
  - state goes to IDLE;
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_mbe=0;
  - last_grant (internal) = instruction side.
- IDLE, data request pending (data_read|data_write): go to SERVE_D.
  - Latch data_addr, data_wdata, data_mbe into the mem_* registers.
  - Set mem_write=data_write and mem_read=~data_write.
  - If data_read and data_write are both high, the write wins.
- IDLE, else if inst_read: go to SERVE_I.
  - Latch inst_addr into mem_addr; mem_read=1, mem_write=0, mem_mbe=0.
- IDLE, no request: stay in IDLE.
- SERVE_x: the mem_* outputs stay constant until mem_resp. Requester inputs that change during SERVE_x are ignored.
- SERVE_x with mem_resp=1:
  - Same cycle: drive x_resp=1 combinationally, and x_rdata=mem_rdata.
  - Next edge: go to IDLE, clear mem_read/mem_write, set last_grant=x.

Outputs and timing:
- inst_rdata and data_rdata are both driven from mem_rdata at all times. Each is qualified only by its own resp.
- inst_resp=1 only in SERVE_I with mem_resp. data_resp=1 only in SERVE_D with mem_resp. The two are never high in the same cycle.
- Minimum latency: request seen in IDLE at edge N; mem strobe high from N+1; response in the same cycle as mem_resp.
- A mandatory IDLE cycle follows every completion, so the requester's still-high strobe in the response cycle is never re-granted.

Boundary conditions:
- mem_resp while in IDLE is ignored: no resp pulse and no state change.
- Both sides pending in IDLE: the data side is granted. This holds unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both sides are pending in IDLE, grant the side opposite to last_grant. Reset makes the data side win the first contention.
- Undefined: fixed priority, data over instruction. last_grant is still maintained but unused.

Test Plan:
1. Reset then single fetch: hold rst=0 for 2 cycles, then rst=1 and inst_read=1 with inst_addr=0x00000060. Required: mem_read=1 with mem_addr=0x60 from the next cycle. Memory returns mem_resp after 3 cycles with mem_rdata=0x00A00093. Required: inst_resp=1 and inst_rdata=0x00A00093 in that cycle, then mem_read=0.
2. Store: data_write=1, data_addr=0x100, data_wdata=0xDEADBEEF, data_mbe=4'b0011. Required: mem_write=1, mem_read=0, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_mbe=0011, all held stable until mem_resp; data_resp pulses one cycle; inst_resp stays 0.
3. Contention: inst_read=1 (addr 0x64) and data_read=1 (addr 0x200) in the same cycle. Fixed-priority build: 0x200 is served first, then one IDLE cycle, then 0x64. Round-robin build after reset: the same order; a repeat contention right after serving data grants 0x64 first.
4. Input change mid-transaction: in SERVE_I, change inst_addr from 0x64 to 0x68 before mem_resp. Required: mem_addr stays 0x64.
5. Reset mid-operation: drive rst=0 in SERVE_D, then assert mem_resp one cycle later. Required: state is IDLE, mem_read=mem_write=0, and data_resp stays 0.
6. Spurious response: mem_resp=1 in IDLE with no requests pending. Required: no resp pulse, mem_* strobes stay 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the split instruction/data request ports of the
// RV32I datapath and the single shared memory port into one interface.
//   slave  - arbiter view (takes requests, drives the shared port)
//   master - environment view (datapath requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // instruction-fetch side
  logic                    inst_read;
  logic [ADDR_WIDTH-1:0]   inst_addr;
  logic [DATA_WIDTH-1:0]   inst_rdata;
  logic                    inst_resp;
  // data-memory side
  logic                    data_read;
  logic                    data_write;
  logic [ADDR_WIDTH-1:0]   data_addr;
  logic [DATA_WIDTH-1:0]   data_wdata;
  logic [DATA_WIDTH/8-1:0] data_mbe;
  logic [DATA_WIDTH-1:0]   data_rdata;
  logic                    data_resp;
  // shared memory/cache side
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_mbe;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_resp;

  modport slave (
    input  inst_read, inst_addr,
    input  data_read, data_write, data_addr, data_wdata, data_mbe,
    input  mem_rdata, mem_resp,
    output inst_rdata, inst_resp,
    output data_rdata, data_resp,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe
  );

  modport master (
    output inst_read, inst_addr,
    output data_read, data_write, data_addr, data_wdata, data_mbe,
    output mem_rdata, mem_resp,
    input  inst_rdata, inst_resp,
    input  data_rdata, data_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges the RV32I instruction-fetch and data-memory ports
// onto one shared memory port. The winning request is latched into registered
// mem_* outputs and held until mem_resp; the completion pulse is routed back
// combinationally to the side being served. Every completion is followed by
// one IDLE cycle so a still-high requester strobe is never re-granted.
// Optional: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on contention
// (opposite of the last served side); otherwise data has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,   // synchronous, active-low
  mem_port_arbiter_if.slave   bus
);

  localparam int MBE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  state_t                 state_reg;
  logic                   last_grant_reg;
  logic                   mem_read_reg;
  logic                   mem_write_reg;
  logic [ADDR_WIDTH-1:0]  mem_addr_reg;
  logic [DATA_WIDTH-1:0]  mem_wdata_reg;
  logic [MBE_WIDTH-1:0]   mem_mbe_reg;

  logic data_req;
  logic grant_data;
  logic inst_done;
  logic data_done;

  assign data_req = bus.data_read | bus.data_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On contention, serve the side that did not win last time.
  assign grant_data = data_req & (~bus.inst_read | (last_grant_reg == GRANT_INST));
`else
  // Fixed priority: any pending data request beats a fetch.
  assign grant_data = data_req;
`endif

  assign inst_done = (state_reg == SERVE_I) & bus.mem_resp;
  assign data_done = (state_reg == SERVE_D) & bus.mem_resp;

  // Response routing: data always mirrors memory, each side qualified by its own pulse.
  assign bus.inst_rdata = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;
  assign bus.inst_resp  = inst_done;
  assign bus.data_resp  = data_done;

  assign bus.mem_read  = mem_read_reg;
  assign bus.mem_write = mem_write_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_mbe   = mem_mbe_reg;

  // Arbitration FSM: grant in IDLE, hold the latched request until mem_resp.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_INST;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_mbe_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_data) begin
            state_reg     <= SERVE_D;
            mem_addr_reg  <= bus.data_addr;
            mem_wdata_reg <= bus.data_wdata;
            mem_mbe_reg   <= bus.data_mbe;
            // a simultaneous read+write is treated as a write
            mem_write_reg <= bus.data_write;
            mem_read_reg  <= ~bus.data_write;
          end else if (bus.inst_read) begin
            state_reg     <= SERVE_I;
            mem_addr_reg  <= bus.inst_addr;
            mem_mbe_reg   <= '0;
            mem_write_reg <= 1'b0;
            mem_read_reg  <= 1'b1;
          end
        end
        SERVE_I: begin
          if (bus.mem_resp) begin
            state_reg      <= IDLE;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            last_grant_reg <= GRANT_INST;
          end
        end
        SERVE_D: begin
          if (bus.mem_resp) begin
            state_reg      <= IDLE;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            last_grant_reg <= GRANT_DATA;
          end
        end
        default: begin
          state_reg     <= IDLE;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
        end
      endcase
    end
  end

  // A completed transaction must be recorded as the most recent grant.
  a_last_grant_tracks_completion: assert property (
    @(posedge clk) disable iff (!rst)
    (inst_done |=> last_grant_reg == GRANT_INST) and
    (data_done |=> last_grant_reg == GRANT_DATA)
  );

endmodule
